spi_sclk_gen: RTL and testbench

//  Parametrised SPI serial-clock generator; successor to the fixed 32-bit clgen. Divides wb_clk to SCLK.

---
 rtl/spi_sclk_gen_pkg.sv | 22 ++
 rtl/spi_halfper_cnt.sv | 35 +++
 rtl/spi_sclk_gen.sv | 207 ++++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_sclk_gen_pkg.sv
// rtl/spi_sclk_gen_pkg.sv - shared types and constants for the SPI serial-clock generator
//
// Contents:
//   state_t          FSM encoding (IDLE / RUN / TAIL)
//   MODE_CPHA/CPOL   bit positions inside the latched mode register
//   DIV_W_DEF        default divider width
//   CNT_W_DEF        default char_len width
package spi_sclk_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    localparam int MODE_CPHA = 0;
    localparam int MODE_CPOL = 1;

    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 7;

endpackage

// File: rtl/spi_halfper_cnt.sv
// rtl/spi_halfper_cnt.sv - reloadable half-period down-counter with zero tick
//
// Ports:
//   wb_clk      in   system clock
//   wb_reset_n  in   synchronous active-low reset
//   load        in   reload counter with load_val (wins over en)
//   en          in   decrement enable; counter parks at zero
//   load_val    in   reload value (half-period minus one)
//   zero        out  counter currently at zero
module spi_halfper_cnt #(
    parameter int W = 16
) (
    input  logic         wb_clk,
    input  logic         wb_reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge wb_clk) begin
        if (!wb_reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SPI serial-clock generator with transfer count and shifter strobes
//
// Ports:
//   wb_clk, wb_reset_n          clock, synchronous active-low reset
//   start, abort                begin transfer (IDLE only) / terminate transfer
//   divider, cpol, cpha,        transfer configuration, latched when start is accepted
//   char_len                    (char_len = 0 means 2**CNT_W bits)
//   busy                        transfer in progress
//   sclk, pos_edge, neg_edge    serial clock and its direction pulses
//   sample_strb, shift_strb,    shifter strobes, high in the cycle sclk shows the new level
//   load_strb
//   last_clk                    final SCLK period of the transfer
//   done                        one-cycle pulse on normal completion
module spi_sclk_gen
    import spi_sclk_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             wb_clk,
    input  logic             wb_reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] divider,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [CNT_W-1:0] char_len,
    output logic             busy,
    output logic             sclk,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             sample_strb,
    output logic             shift_strb,
    output logic             load_strb,
    output logic             last_clk,
    output logic             done
);

    localparam int TW = CNT_W + 1;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] len_q;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    logic busy_d, sclk_d, pos_d, neg_d, sample_d, shift_d, load_d, last_d, done_d;
    logic accept;
    logic cnt_load, cnt_en, tick;

    // tcnt_q holds the number of toggles already issued, so the toggle being
    // issued now has index t = tcnt_q + 1. With n_m1 = N-1 (char_len 0 wraps
    // to 2**CNT_W - 1), t = 2N is tcnt_q = {n_m1,1} and t = 2N-2 is {n_m1-1,1}.
    logic [CNT_W-1:0] n_m1;
    logic [TW-1:0]    last_idx;
    logic [TW-1:0]    pre_last_idx;
    logic             is_last_tog;
    logic             cpha_q, cpol_q;

    assign n_m1         = len_q - CNT_W'(1);
    assign last_idx     = {n_m1, 1'b1};
    assign pre_last_idx = {n_m1 - CNT_W'(1), 1'b1};
    assign is_last_tog  = (tcnt_q == last_idx);
    assign cpha_q       = mode_q[MODE_CPHA];
    assign cpol_q       = mode_q[MODE_CPOL];

    spi_halfper_cnt #(
        .W(DIV_W)
    ) u_halfper_cnt (
        .wb_clk    (wb_clk),
        .wb_reset_n(wb_reset_n),
        .load      (cnt_load),
        .en        (cnt_en),
        // on accept the shadow register is not yet valid, so load from the input
        .load_val  (accept ? divider : div_q),
        .zero      (tick)
    );

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        busy_d   = busy;
        sclk_d   = sclk;
        pos_d    = 1'b0;
        neg_d    = 1'b0;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        load_d   = 1'b0;
        last_d   = last_clk;
        done_d   = 1'b0;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol;
                busy_d = 1'b0;
                last_d = 1'b0;
                tcnt_d = '0;
                if (start && !abort) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_RUN;
                    busy_d   = 1'b1;
                    load_d   = !cpha;
                    // a one-bit transfer is in its last SCLK period immediately
                    last_d   = (char_len == CNT_W'(1));
                end
            end

            ST_RUN: begin
                cnt_en = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sclk_d  = cpol_q;
                    last_d  = 1'b0;
                    tcnt_d  = '0;
                end else if (tick) begin
                    cnt_load = 1'b1;
                    sclk_d   = !sclk;
                    pos_d    = !sclk;
                    neg_d    = sclk;
                    tcnt_d   = tcnt_q + TW'(1);
                    if (!tcnt_q[0]) begin
                        // leading edge
                        sample_d = !cpha_q;
                        shift_d  = cpha_q;
                    end else begin
                        // trailing edge; no shift after the final bit in cpha=0
                        sample_d = cpha_q;
                        shift_d  = !cpha_q && !is_last_tog;
                    end
                    if (tcnt_q == pre_last_idx) begin
                        last_d = 1'b1;
                    end
                    if (is_last_tog) begin
                        state_d = ST_TAIL;
                    end
                end
            end

            ST_TAIL: begin
                cnt_en = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sclk_d  = cpol_q;
                    last_d  = 1'b0;
                    tcnt_d  = '0;
                end else if (tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    tcnt_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                last_d  = 1'b0;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_reset_n) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            div_q       <= '0;
            mode_q      <= '0;
            len_q       <= '0;
            busy        <= 1'b0;
            sclk        <= 1'b0;
            pos_edge    <= 1'b0;
            neg_edge    <= 1'b0;
            sample_strb <= 1'b0;
            shift_strb  <= 1'b0;
            load_strb   <= 1'b0;
            last_clk    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            busy        <= busy_d;
            sclk        <= sclk_d;
            pos_edge    <= pos_d;
            neg_edge    <= neg_d;
            sample_strb <= sample_d;
            shift_strb  <= shift_d;
            load_strb   <= load_d;
            last_clk    <= last_d;
            done        <= done_d;
            if (accept) begin
                div_q             <= divider;
                mode_q[MODE_CPHA] <= cpha;
                mode_q[MODE_CPOL] <= cpol;
                len_q             <= char_len;
            end
        end
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - directed self-checking bench for spi_sclk_gen
module tb_spi_sclk_gen;

    logic        wb_clk = 1'b0;
    logic        wb_reset_n;
    logic        start;
    logic        abort;
    logic [15:0] divider;
    logic        cpol;
    logic        cpha;
    logic [6:0]  char_len;
    logic        busy, sclk, pos_edge, neg_edge, sample_strb, shift_strb;
    logic        load_strb, last_clk, done;

    int tests = 0;
    int fails = 0;

    // per-cycle capture: {busy,sclk,pos,neg,sample,shift,load,last,done}
    logic [8:0] tr [0:299];

    always #5 wb_clk = ~wb_clk;

    spi_sclk_gen #(
        .DIV_W(16),
        .CNT_W(7)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_reset_n (wb_reset_n),
        .start      (start),
        .abort      (abort),
        .divider    (divider),
        .cpol       (cpol),
        .cpha       (cpha),
        .char_len   (char_len),
        .busy       (busy),
        .sclk       (sclk),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .sample_strb(sample_strb),
        .shift_strb (shift_strb),
        .load_strb  (load_strb),
        .last_clk   (last_clk),
        .done       (done)
    );

    function automatic logic [8:0] outs();
        return {busy, sclk, pos_edge, neg_edge, sample_strb, shift_strb,
                load_strb, last_clk, done};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycle k is the negedge after the k-th posedge, k=1 being the edge that
    // samples start. mode 1: reconfigure and re-pulse start mid-transfer;
    // mode 2: pulse reset low for the edge of cycle 5.
    task automatic capture(input int n, input int abort_k, input int mode);
        for (int k = 1; k <= n; k++) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
            tr[k]      = outs();
            start      = 1'b0;
            abort      = (k == abort_k - 1);
            if (mode == 1) begin
                if (k == 2) begin
                    divider = 16'd5; cpol = 1'b1; cpha = 1'b1; char_len = 7'd5;
                end
                if (k == 3) start = 1'b1;
                if (k == 9) begin
                    divider = 16'd1; cpol = 1'b0; cpha = 1'b0; char_len = 7'd2;
                end
            end
            if (mode == 2) wb_reset_n = (k != 4);
        end
    endtask

    task automatic check_trace(input string tag, input int n,
                               input logic [31:0] m_busy, input logic [31:0] m_sclk,
                               input logic [31:0] m_pos, input logic [31:0] m_neg,
                               input logic [31:0] m_samp, input logic [31:0] m_shift,
                               input logic [31:0] m_load, input logic [31:0] m_last,
                               input logic [31:0] m_done);
        logic [8:0] exp;
        for (int k = 1; k <= n; k++) begin
            exp = {m_busy[k], m_sclk[k], m_pos[k], m_neg[k], m_samp[k],
                   m_shift[k], m_load[k], m_last[k], m_done[k]};
            tests++;
            assert (tr[k] === exp) else begin
                fails++;
                $error("FAIL %s E%0d observed=%b expected=%b", tag, k, tr[k], exp);
            end
        end
    endtask

    task automatic cfg(input int div, input logic pol, input logic pha, input int len);
        divider  = div[15:0];
        cpol     = pol;
        cpha     = pha;
        char_len = len[6:0];
    endtask

    initial begin
        int c_pos, c_neg, c_samp, c_shift, c_load, c_busy, c_last;
        int first_tog, last_tog, done_at;

        wb_reset_n = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cfg(0, 1'b1, 1'b0, 1);
        repeat (3) @(negedge wb_clk);
        chk("reset_outputs", int'(outs()), 0);
        wb_reset_n = 1'b1;

        // 1: div=1 cpol=0 cpha=0 len=2
        cfg(1, 1'b0, 1'b0, 2);
        repeat (2) @(negedge wb_clk);
        chk("idle_sclk_cpol0", int'(sclk), 0);
        start = 1'b1;
        capture(12, 0, 0);
        check_trace("mode0", 12, 32'h7FE, 32'h198, 32'h88, 32'h220, 32'h88,
                    32'h20, 32'h2, 32'h7E0, 32'h800);

        // 2: cpol=1 cpha=1
        cfg(1, 1'b1, 1'b1, 2);
        repeat (2) @(negedge wb_clk);
        chk("idle_sclk_cpol1", int'(sclk), 1);
        start = 1'b1;
        capture(12, 0, 0);
        check_trace("mode3", 12, 32'h7FE, 32'h1E66, 32'h220, 32'h88, 32'h220,
                    32'h88, 32'h0, 32'h7E0, 32'h800);

        // 3: div=0 len=0 -> 128 bits, 256 toggles
        cfg(0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge wb_clk);
        start = 1'b1;
        capture(262, 0, 0);
        c_pos = 0; c_neg = 0; c_samp = 0; c_shift = 0; c_load = 0;
        c_busy = 0; c_last = 0; first_tog = 0; last_tog = 0; done_at = 0;
        for (int k = 1; k <= 262; k++) begin
            c_busy  += int'(tr[k][8]);
            c_pos   += int'(tr[k][6]);
            c_neg   += int'(tr[k][5]);
            c_samp  += int'(tr[k][4]);
            c_shift += int'(tr[k][3]);
            c_load  += int'(tr[k][2]);
            c_last  += int'(tr[k][1]);
            if (tr[k][0]) done_at = k;
            if (tr[k][6] || tr[k][5]) begin
                if (first_tog == 0) first_tog = k;
                last_tog = k;
            end
        end
        chk("len0_pos", c_pos, 128);
        chk("len0_neg", c_neg, 128);
        chk("len0_sample", c_samp, 128);
        chk("len0_shift", c_shift, 127);
        chk("len0_load", c_load, 1);
        chk("len0_busy", c_busy, 257);
        chk("len0_last_clk", c_last, 3);
        chk("len0_first_toggle", first_tog, 2);
        chk("len0_last_toggle", last_tog, 257);
        chk("len0_done_at", done_at, 258);

        // 4: abort after the 3rd toggle, then a 1-bit transfer
        cfg(3, 1'b1, 1'b0, 8);
        repeat (2) @(negedge wb_clk);
        start = 1'b1;
        capture(30, 14, 0);
        check_trace("abort", 30, 32'h3FFE, 32'h7FFFDE1E, 32'h200, 32'h2020,
                    32'h2020, 32'h200, 32'h2, 32'h0, 32'h0);
        cfg(0, 1'b1, 1'b0, 1);
        start = 1'b1;
        capture(6, 0, 0);
        check_trace("after_abort_len1", 6, 32'hE, 32'h7A, 32'h8, 32'h4,
                    32'h4, 32'h0, 32'h2, 32'hE, 32'h10);

        // 5: config changes and start pulse while busy are ignored
        cfg(1, 1'b0, 1'b0, 2);
        repeat (2) @(negedge wb_clk);
        start = 1'b1;
        capture(12, 0, 1);
        check_trace("shadow", 12, 32'h7FE, 32'h198, 32'h88, 32'h220, 32'h88,
                    32'h20, 32'h2, 32'h7E0, 32'h800);

        // 6: reset pulse mid-RUN
        cfg(1, 1'b1, 1'b0, 2);
        repeat (2) @(negedge wb_clk);
        start = 1'b1;
        capture(12, 0, 2);
        check_trace("mid_reset", 12, 32'h1E, 32'h1FC6, 32'h0, 32'h8, 32'h8,
                    32'h0, 32'h2, 32'h0, 32'h0);

        // 7: start together with abort in IDLE is ignored
        cfg(1, 1'b0, 1'b0, 2);
        repeat (2) @(negedge wb_clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        @(negedge wb_clk);
        chk("start_abort_outs", int'(outs()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
